// File: rtl/ifetch_queue.sv
// ifetch_queue: decoupled instruction fetch unit that runs ahead of decode.
// Fetches cache lines over the L1/MMU port, extracts the 32-bit word at
// fetch_pc and buffers {instruction, pc} in a DEPTH-entry FIFO. Redirects
// (do_jump / is_sync_ins) flush the queue and cancel any in-flight fetch.
// Optional feature: define IFQ_LINE_BUF_EN to add a one-line buffer that
// serves sequential PCs within the last returned line without a new request.
module ifetch_queue #(
    parameter int          LINE_BITS = 256,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'hFFFFE000,
    parameter logic [31:0] WRAP_PC   = 32'h00008000
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      do_jump,
    input  logic [31:0]               jump_addr,
    input  logic                      is_sync_ins,
    input  logic [31:0]               sync_pc,
    input  logic                      fetch_bubble,
    input  logic                      deq,
    output logic                      ins_valid,
    output logic [31:0]               ins_out,
    output logic [31:0]               pc_out,
    output logic [31:0]               next_pc_out,
    output logic                      global_stall,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      mem_req,
    output logic [31:0]               mem_addr,
    input  logic                      mem_done,
    input  logic [LINE_BITS-1:0]      mem_data
);

    localparam int OFFS   = $clog2(LINE_BITS / 8);
    localparam int WSEL_W = OFFS - 2;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [31:0]          r_fetch_pc;
    logic                 r_mem_req;
    logic [31:0]          r_mem_addr;

    logic [31:0]          r_ins_mem [DEPTH];
    logic [31:0]          r_pc_mem  [DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 r_ins_valid;
    logic [31:0]          r_ins_out;
    logic [31:0]          r_pc_out;
    logic [31:0]          r_next_pc_out;

    logic                 w_redirect;
    logic [31:0]          w_redirect_pc;
    logic                 w_has_room;
    logic [WSEL_W-1:0]    w_wsel;
    logic [31:0]          w_mem_word;
    logic [31:0]          w_push_ins;
    logic                 w_lb_hit;
    logic                 w_issue;
    logic                 w_mem_push;
    logic                 w_mem_end;
    logic                 w_push;
    logic                 w_pop;
    logic [PTR_W-1:0]     w_next_rd;
    logic [PTR_W-1:0]     w_next_wr;
    logic [CNT_W-1:0]     w_next_count;
    logic [31:0]          w_head_ins;
    logic [31:0]          w_head_pc;

    // A sync takes priority over a jump when both arrive together.
    assign w_redirect    = do_jump | is_sync_ins;
    assign w_redirect_pc = is_sync_ins ? sync_pc : jump_addr;
    assign w_has_room    = (r_count < CNT_W'(DEPTH));
    assign w_wsel        = r_fetch_pc[OFFS-1:2];
    assign w_mem_word    = mem_data[{w_wsel, 5'b00000} +: 32];

`ifdef IFQ_LINE_BUF_EN
    logic                 r_lb_valid;
    logic [31-OFFS:0]     r_lb_tag;
    logic [LINE_BITS-1:0] r_lb_data;
    logic [31:0]          w_lb_word;

    assign w_lb_word  = r_lb_data[{w_wsel, 5'b00000} +: 32];
    assign w_lb_hit   = (r_state == S_IDLE) && r_lb_valid &&
                        (r_lb_tag == r_fetch_pc[31:OFFS]) &&
                        w_has_room && !w_redirect;
    assign w_push_ins = w_mem_push ? w_mem_word : w_lb_word;

    // Line buffer captures every accepted line; a sync may have changed
    // memory contents so it invalidates, while a plain jump keeps the line.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_lb_valid <= 1'b0;
            r_lb_tag   <= '0;
            r_lb_data  <= '0;
        end else if (is_sync_ins) begin
            r_lb_valid <= 1'b0;
        end else if (w_mem_push) begin
            r_lb_valid <= 1'b1;
            r_lb_tag   <= r_mem_addr[31:OFFS];
            r_lb_data  <= mem_data;
        end
    end
`else
    assign w_lb_hit   = 1'b0;
    assign w_push_ins = w_mem_word;
`endif

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: issue only with room and no bubble/redirect; a
    // redirect during an outstanding request waits in DROP for its data.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_has_room && !fetch_bubble && !w_redirect && !w_lb_hit) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_done) begin
                    w_next_state = S_IDLE;
                end else if (w_redirect) begin
                    w_next_state = S_DROP;
                end
            end
            S_DROP: begin
                if (mem_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: request issue, completion, and whether returned data is kept.
    always_comb begin
        w_issue    = 1'b0;
        w_mem_push = 1'b0;
        w_mem_end  = 1'b0;
        case (r_state)
            S_IDLE: w_issue = (w_next_state == S_REQ);
            S_REQ: begin
                w_mem_end  = mem_done;
                w_mem_push = mem_done && !w_redirect;
            end
            S_DROP: w_mem_end = mem_done;
            default: w_issue = 1'b0;
        endcase
    end

    assign w_push = w_mem_push | w_lb_hit;
    assign w_pop  = deq && (r_count != '0) && !w_redirect;

    // Next queue pointers and occupancy; a redirect empties the queue.
    always_comb begin
        w_next_rd    = r_rd_ptr;
        w_next_wr    = r_wr_ptr;
        w_next_count = r_count;
        if (w_redirect) begin
            w_next_rd    = '0;
            w_next_wr    = '0;
            w_next_count = '0;
        end else begin
            if (w_push) begin
                w_next_wr = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_next_rd = r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                w_next_count = r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                w_next_count = r_count - CNT_W'(1);
            end
        end
    end

    // Head entry after this cycle's update, bypassing a push into an empty slot
    // so a fresh instruction reaches the outputs one cycle after mem_done.
    always_comb begin
        w_head_ins = r_ins_mem[w_next_rd];
        w_head_pc  = r_pc_mem[w_next_rd];
        if (w_push && (r_wr_ptr == w_next_rd)) begin
            w_head_ins = w_push_ins;
            w_head_pc  = r_fetch_pc;
        end
    end

    // Queue storage; contents need no reset since pointers define validity.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_ins_mem[r_wr_ptr] <= w_push_ins;
            r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
        end
    end

    // Queue pointers and occupancy count.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_next_rd;
            r_wr_ptr <= w_next_wr;
            r_count  <= w_next_count;
        end
    end

    // Fetch PC: redirect target, else sequential advance with wrap on each push.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= (r_fetch_pc == WRAP_PC) ? RESET_PC : r_fetch_pc + 32'd4;
        end
    end

    // Memory request: raised with a line-aligned address on issue, dropped on completion.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else if (w_issue) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_fetch_pc[31:OFFS], {OFFS{1'b0}}};
        end else if (w_mem_end) begin
            r_mem_req  <= 1'b0;
        end
    end

    // Registered head outputs, zeroed whenever the queue will be empty.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ins_valid   <= 1'b0;
            r_ins_out     <= '0;
            r_pc_out      <= '0;
            r_next_pc_out <= '0;
        end else if (w_next_count != '0) begin
            r_ins_valid   <= 1'b1;
            r_ins_out     <= w_head_ins;
            r_pc_out      <= w_head_pc;
            r_next_pc_out <= w_head_pc + 32'd4;
        end else begin
            r_ins_valid   <= 1'b0;
            r_ins_out     <= '0;
            r_pc_out      <= '0;
            r_next_pc_out <= '0;
        end
    end

    assign ins_valid    = r_ins_valid;
    assign ins_out      = r_ins_out;
    assign pc_out       = r_pc_out;
    assign next_pc_out  = r_next_pc_out;
    assign global_stall = !r_ins_valid;
    assign q_count      = r_count;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: memory responder with fixed latency, an ordered
// scoreboard of expected {pc, instruction} pops, and directed redirect, wrap,
// bubble and (with IFQ_LINE_BUF_EN) line-buffer scenarios.
module tb_ifetch_queue;

    localparam int          LINE_BITS = 256;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_PC  = 32'hFFFFE000;
    localparam logic [31:0] WRAP_PC   = 32'h00008000;
    localparam int          MEM_LAT   = 2;

    logic                   sys_clk = 1'b0;
    logic                   rst;
    logic                   do_jump;
    logic [31:0]            jump_addr;
    logic                   is_sync_ins;
    logic [31:0]            sync_pc;
    logic                   fetch_bubble;
    logic                   deq;
    logic                   ins_valid;
    logic [31:0]            ins_out;
    logic [31:0]            pc_out;
    logic [31:0]            next_pc_out;
    logic                   global_stall;
    logic [$clog2(DEPTH):0] q_count;
    logic                   mem_req;
    logic [31:0]            mem_addr;
    logic                   mem_done;
    logic [LINE_BITS-1:0]   mem_data;

    int          assertCount;
    int          failCount;
    int          cycleNo;
    logic [31:0] sbPc [$];
    logic [31:0] modelPc;
    logic        memPending;
    int          memCnt;
    logic [31:0] memAddr;
    logic [31:0] lastReqAddr;
    int          reqCount;
    int          popCount;
    logic        lastDone;
    logic [31:0] prevPopPc;
    logic        sawWrap;
    int          popCycles [$];
    int          reqSnap;
    int          popSnap;

    ifetch_queue #(
        .LINE_BITS (LINE_BITS),
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC),
        .WRAP_PC   (WRAP_PC)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .do_jump      (do_jump),
        .jump_addr    (jump_addr),
        .is_sync_ins  (is_sync_ins),
        .sync_pc      (sync_pc),
        .fetch_bubble (fetch_bubble),
        .deq          (deq),
        .ins_valid    (ins_valid),
        .ins_out      (ins_out),
        .pc_out       (pc_out),
        .next_pc_out  (next_pc_out),
        .global_stall (global_stall),
        .q_count      (q_count),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_done     (mem_done),
        .mem_data     (mem_data)
    );

    // Free-running clock.
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] nextPc(input logic [31:0] pc);
        return (pc == WRAP_PC) ? RESET_PC : pc + 32'd4;
    endfunction

    // Memory word k of line A is {A[15:0], k}; seen from the PC that selects it.
    function automatic logic [31:0] expIns(input logic [31:0] pc);
        return {pc[15:5], 5'b00000, 13'd0, pc[4:2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic sbTopUp();
        while (sbPc.size() < 16) begin
            sbPc.push_back(modelPc);
            modelPc = nextPc(modelPc);
        end
    endtask

    task automatic sbRestart(input logic [31:0] target);
        sbPc.delete();
        modelPc = target;
        sbTopUp();
    endtask

    // One clock cycle: score any pop, model redirects, run the memory responder.
    task automatic applyStimulus();
        logic [31:0] expPc;
        if (!rst && ins_valid === 1'b1 && deq && !do_jump && !is_sync_ins) begin
            expPc = sbPc.pop_front();
            checkOutput("pop_pc", pc_out, expPc);
            checkOutput("pop_ins", ins_out, expIns(expPc));
            checkOutput("pop_next_pc", next_pc_out, expPc + 32'd4);
            if (expPc == RESET_PC && prevPopPc == WRAP_PC) sawWrap = 1'b1;
            prevPopPc = expPc;
            popCount++;
            popCycles.push_back(cycleNo);
            sbTopUp();
        end
        if (!rst && (do_jump || is_sync_ins)) begin
            sbRestart(is_sync_ins ? sync_pc : jump_addr);
            prevPopPc = '0;
        end
        mem_done = 1'b0;
        if (rst) begin
            memPending = 1'b0;
        end else begin
            if (mem_req === 1'b1 && !memPending) begin
                memPending  = 1'b1;
                memCnt      = MEM_LAT;
                memAddr     = mem_addr;
                lastReqAddr = mem_addr;
                reqCount++;
            end
            if (memPending) begin
                if (memCnt == 0) begin
                    mem_done   = 1'b1;
                    memPending = 1'b0;
                    for (int k = 0; k < LINE_BITS / 32; k++) begin
                        mem_data[32*k +: 32] = {memAddr[15:0], 16'(k)};
                    end
                end else begin
                    memCnt--;
                end
            end
        end
        lastDone = mem_done;
        @(posedge sys_clk);
        #1;
        cycleNo++;
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (ins_valid === 1'b1) break;
            applyStimulus();
        end
        checkOutput(tag, ins_valid, 1'b1);
    endtask

    // Directed sequence.
    initial begin
        assertCount = 0; failCount = 0; cycleNo = 0;
        reqCount = 0; popCount = 0; memPending = 1'b0; memCnt = 0;
        memAddr = '0; lastReqAddr = '0; lastDone = 1'b0;
        prevPopPc = '0; sawWrap = 1'b0; modelPc = RESET_PC;
        rst = 1'b1; do_jump = 1'b0; jump_addr = '0; is_sync_ins = 1'b0;
        sync_pc = '0; fetch_bubble = 1'b0; deq = 1'b0;
        mem_done = 1'b0; mem_data = '0;

        repeat (3) applyStimulus();
        checkOutput("rst_valid", ins_valid, 1'b0);
        checkOutput("rst_ins", ins_out, 32'd0);
        checkOutput("rst_pc", pc_out, 32'd0);
        checkOutput("rst_next_pc", next_pc_out, 32'd0);
        checkOutput("rst_count", q_count, 0);
        checkOutput("rst_mem_req", mem_req, 1'b0);
        checkOutput("rst_stall", global_stall, 1'b1);

        rst = 1'b0;
        sbRestart(RESET_PC);

        $display("[TB] fill after reset, deq low");
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (lastDone) break;
        end
        checkOutput("first_done_seen", lastDone, 1'b1);
        checkOutput("first_req_addr", lastReqAddr, RESET_PC);
        checkOutput("first_valid_latency", ins_valid, 1'b1);
        checkOutput("first_pc", pc_out, RESET_PC);
        checkOutput("first_ins", ins_out, expIns(RESET_PC));
        checkOutput("first_stall", global_stall, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (q_count == DEPTH) break;
            applyStimulus();
        end
        repeat (8) applyStimulus();
        checkOutput("full_count", q_count, DEPTH);
        checkOutput("full_no_req", mem_req, 1'b0);
        checkOutput("full_req_total", reqCount, DEPTH);

        $display("[TB] drain with deq held high");
        deq = 1'b1;
        popSnap = popCount;
        repeat (24) applyStimulus();
        checkOutput("pop_progress", (popCount - popSnap) >= 7, 1'b1);

        $display("[TB] jump while request outstanding");
        for (int i = 0; i < 20; i++) begin
            if (memPending && memCnt != 0) break;
            applyStimulus();
        end
        checkOutput("drop_setup", memPending && memCnt != 0, 1'b1);
        reqSnap = reqCount;
        do_jump = 1'b1; jump_addr = 32'h00001000;
        applyStimulus();
        do_jump = 1'b0;
        checkOutput("jump_flush_valid", ins_valid, 1'b0);
        checkOutput("jump_flush_count", q_count, 0);
        checkOutput("jump_flush_ins", ins_out, 32'd0);
        checkOutput("jump_flush_stall", global_stall, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (reqCount != reqSnap) break;
            applyStimulus();
        end
        checkOutput("drop_next_addr", lastReqAddr, 32'h00001000);
        waitValid("drop_valid_seen");
        checkOutput("drop_first_pc", pc_out, 32'h00001000);

        $display("[TB] jump coincident with mem_done");
        for (int i = 0; i < 20; i++) begin
            if (memPending && memCnt == 0) break;
            applyStimulus();
        end
        checkOutput("same_cycle_setup", memPending && memCnt == 0, 1'b1);
        do_jump = 1'b1; jump_addr = 32'h00003000;
        applyStimulus();
        do_jump = 1'b0;
        checkOutput("same_cycle_count", q_count, 0);
        checkOutput("same_cycle_valid", ins_valid, 1'b0);
        waitValid("same_cycle_valid_seen");
        checkOutput("same_cycle_first_pc", pc_out, 32'h00003000);

        $display("[TB] sync and jump together");
        do_jump = 1'b1; jump_addr = 32'h00005000;
        is_sync_ins = 1'b1; sync_pc = 32'h00004000;
        applyStimulus();
        do_jump = 1'b0; is_sync_ins = 1'b0;
        waitValid("sync_valid_seen");
        checkOutput("sync_first_pc", pc_out, 32'h00004000);

        $display("[TB] fetch bubble with empty queue");
        fetch_bubble = 1'b1;
        do_jump = 1'b1; jump_addr = 32'h00006000;
        applyStimulus();
        do_jump = 1'b0;
        repeat (6) applyStimulus();
        checkOutput("bubble_no_issue", mem_req, 1'b0);
        checkOutput("bubble_empty_count", q_count, 0);
        checkOutput("bubble_empty_valid", ins_valid, 1'b0);
        fetch_bubble = 1'b0;
        waitValid("bubble_release_valid");
        checkOutput("bubble_first_pc", pc_out, 32'h00006000);

        $display("[TB] sequential fetch across wrap PC");
        do_jump = 1'b1; jump_addr = 32'h00007FF8;
        applyStimulus();
        do_jump = 1'b0;
        sawWrap = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sawWrap) break;
            applyStimulus();
        end
        checkOutput("wrap_seen", sawWrap, 1'b1);

`ifdef IFQ_LINE_BUF_EN
        $display("[TB] line buffer");
        deq = 1'b0;
        repeat (20) applyStimulus();
        reqSnap = reqCount;
        is_sync_ins = 1'b1; sync_pc = 32'h00002000;
        applyStimulus();
        is_sync_ins = 1'b0;
        repeat (20) applyStimulus();
        checkOutput("lb_first_fill", q_count, DEPTH);
        checkOutput("lb_one_req", reqCount - reqSnap, 1);

        reqSnap = reqCount;
        deq = 1'b1;
        do_jump = 1'b1; jump_addr = 32'h00002000;
        applyStimulus();
        do_jump = 1'b0;
        popCycles.delete();
        for (int i = 0; i < 30; i++) begin
            applyStimulus();
            if (prevPopPc == 32'h0000201C) break;
        end
        checkOutput("lb_no_req", reqCount - reqSnap, 0);
        checkOutput("lb_pop_count", popCycles.size(), 8);
        checkOutput("lb_pop_span",
                    (popCycles.size() >= 8) ? popCycles[7] - popCycles[0] : -1, 7);

        deq = 1'b0;
        repeat (20) applyStimulus();
        reqSnap = reqCount;
        is_sync_ins = 1'b1; sync_pc = 32'h00002020;
        applyStimulus();
        is_sync_ins = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (reqCount != reqSnap) break;
            applyStimulus();
        end
        checkOutput("lb_sync_refetch", reqCount - reqSnap, 1);
        checkOutput("lb_sync_addr", lastReqAddr, 32'h00002020);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised decoupled instruction fetch unit that runs ahead of decode.
- It fetches cache lines from the L1/MMU port, extracts 32-bit instructions, and buffers them with their PCs in a DEPTH-entry FIFO.
- Decode consumes entries with a valid/ready handshake. Redirects from execute and sync instructions flush the queue and cancel in-flight fetches.
- It sits between the L1 instruction memory port and decode, and supersedes the single-entry fetch stage.

Parameters:
- LINE_BITS, 256, memory line width in bits; power of two, 64..1024.
- DEPTH, 4, instruction queue entries; power of two, 2..16.
- RESET_PC, 32'hFFFFE000, fetch PC after reset.
- WRAP_PC, 32'h00008000, when the sequential fetch PC equals this value, the next fetch PC is RESET_PC.

Ports:
- sys_clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- do_jump  in  1  redirect request from execute.
- jump_addr  in  32  redirect target, word aligned.
- is_sync_ins  in  1  sync instruction retired; flush and refetch from its successor (sync_pc).
- sync_pc  in  32  PC at which to restart after a sync.
- fetch_bubble  in  1  inhibits issuing a new memory request this cycle.
- deq  in  1  decode accepts the head entry (ready).
- ins_valid  out  1  head entry valid.
- ins_out  out  32  head instruction; 0 when !ins_valid.
- pc_out  out  32  head PC.
- next_pc_out  out  32  pc_out + 4.
- global_stall  out  1  equals !ins_valid.
- q_count  out  $clog2(DEPTH)+1  occupied entries.
- mem_req  out  1  line read request, held high until mem_done.
- mem_addr  out  32  line-aligned address of fetch_pc.
- mem_done  in  1  one-cycle pulse, mem_data valid.
- mem_data  in  LINE_BITS  returned line.

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; queue empty; state IDLE.
  - mem_req = 0, ins_valid = 0, ins_out = 0, pc_out = 0, next_pc_out = 0, q_count = 0.
  - The memory port is reset by the same rst. Any mem_done seen while not in REQ/DROP is ignored.
- Word select: instruction = mem_data[32*w +: 32], where w = fetch_pc[$clog2(LINE_BITS/8)-1:2].
- FSM states: IDLE, REQ, DROP.
  - IDLE -> REQ when q_count < DEPTH and !fetch_bubble and !do_jump and !is_sync_ins. mem_req and mem_addr are registered and change only on that transition.
  - REQ with mem_done: write {instruction, fetch_pc} at the tail. fetch_pc <= (fetch_pc == WRAP_PC) ? RESET_PC : fetch_pc + 4. Go to IDLE.
  - REQ with redirect (do_jump or is_sync_ins) and no mem_done -> DROP.
  - DROP: mem_req stays high. On mem_done the data is discarded and the state goes to IDLE.
- At most one request is outstanding.
- Occupancy: a fetch is issued only when q_count < DEPTH, so a completing fetch never overflows the queue.
  - Same-cycle push and pop: q_count unchanged.
  - deq while empty: ignored.
- Latency: mem_done in cycle t puts the entry on the outputs in cycle t+1 if the queue was empty.
  - Back-to-back misses give a throughput of one instruction per memory round trip plus 1 cycle.
- Redirect (do_jump or is_sync_ins):
  - Queue cleared next cycle; ins_valid = 0 next cycle.
  - fetch_pc <= jump_addr, or sync_pc for a sync.
  - If both are asserted, is_sync_ins wins.
  - A redirect beats a same-cycle mem_done; that data is dropped.
  - deq in the redirect cycle is ignored.
- A redirect in DROP updates fetch_pc and the state stays DROP.
- fetch_bubble only blocks new issue. In-flight completions and deq proceed.
- Every output is registered except global_stall, which is combinational from ins_valid.

Optional Feature:
- Macro IFQ_LINE_BUF_EN.
- Defined:
  - A one-line buffer holds the last returned line and its tag (address[31:$clog2(LINE_BITS/8)]).
  - In IDLE, if fetch_pc hits the tag and q_count < DEPTH, the instruction is pushed directly from the buffer with no memory request: one instruction per cycle, fetch_pc advances.
  - The buffer is invalidated on rst and on is_sync_ins. do_jump keeps it.
  - Data dropped in DROP is not written to the buffer.
- Not defined: every instruction costs one memory request; no buffer state exists.

Test Plan:
- Reset release, memory returns mem_done 2 cycles after mem_req with word k = k -> queue fills with instructions 0..7 at PCs FFFFE000.., ins_valid first high 1 cycle after first mem_done, q_count stops at DEPTH=4 with deq=0.
- Full queue, deq held high -> entries pop in PC order, next_pc_out = pc_out+4, q_count refills, no entry lost or duplicated.
- do_jump to 32'h00001000 while in REQ -> DROP, returned line discarded, next mem_addr = 32'h00001000, first valid pc_out = 32'h00001000.
- do_jump and mem_done in the same cycle -> no push, queue empty next cycle, fetch restarts at jump_addr. is_sync_ins with do_jump -> fetch_pc = sync_pc.
- Sequential fetch reaches PC 32'h00008000 -> that instruction is queued, next fetched PC = 32'hFFFFE000.
- With IFQ_LINE_BUF_EN: eight sequential PCs in one 256-bit line -> exactly one mem_req, 8 pushes on consecutive cycles. After is_sync_ins -> a fresh mem_req occurs for the same line.
